// File: rtl/sobel_pkg.sv
// Shared types and frame constants for the Sobel frame sequencer.
// Gradient struct width follows SOBEL_WIDTH; the top's WIDTH_P must match it.
package sobel_pkg;

    localparam int SOBEL_WIDTH = 8;
    localparam int SOBEL_IMG_W = 16;
    localparam int SOBEL_IMG_H = 16;
    localparam int GRAD_W      = 2 * SOBEL_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } sobel_state_e;

    typedef struct packed {
        logic signed [GRAD_W-1:0] gx;
        logic signed [GRAD_W-1:0] gy;
        logic                     last;
    } grad_t;

    function automatic int flush_beats(input int img_w);
        return 2 * img_w;
    endfunction

    function automatic int out_per_frame(input int img_w, input int img_h);
        return (img_h - 2) * (img_w - 2);
    endfunction

    localparam int FLUSH_BEATS   = flush_beats(SOBEL_IMG_W);
    localparam int OUT_PER_FRAME = out_per_frame(SOBEL_IMG_W, SOBEL_IMG_H);

endpackage

// File: rtl/sobel_grad_fifo.sv
// Two-entry gradient FIFO; head is visible combinationally, zero-latency pop.
// Simultaneous push and pop are both honoured, including when full.
module sobel_grad_fifo
    import sobel_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  grad_t      i_dat,
    input  logic       i_pop,
    output grad_t      o_dat,
    output logic       o_full,
    output logic       o_empty,
    output logic [1:0] o_cnt
);

    grad_t      r_mem [2];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_cnt;
    logic       w_push;
    logic       w_pop;

    assign o_full  = (r_cnt == 2'd2);
    assign o_empty = (r_cnt == 2'd0);
    assign o_cnt   = r_cnt;
    assign o_dat   = r_mem[r_rptr];

    assign w_pop  = i_pop & ~o_empty;
    // A push into a full FIFO is only safe when the head leaves in the same cycle.
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_dat;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer in front of conv2d: flushes line buffers, streams one frame, tags interior windows.
// Accept-to-m_valid latency 2 cycles; credit (fifo + in-flight < 2) throttles upstream under backpressure.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int WIDTH_P = SOBEL_WIDTH,
    parameter int IMG_W_P = SOBEL_IMG_W,
    parameter int IMG_H_P = SOBEL_IMG_H
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        start_i,
    input  logic                        s_valid_i,
    output logic                        s_ready_o,
    input  logic [WIDTH_P-1:0]          s_data_i,
    output logic                        conv_valid_o,
    input  logic                        conv_ready_i,
    output logic [WIDTH_P-1:0]          conv_data_o,
    input  logic signed [2*WIDTH_P-1:0] conv_gx_i,
    input  logic signed [2*WIDTH_P-1:0] conv_gy_i,
    output logic                        m_valid_o,
    input  logic                        m_ready_i,
    output logic signed [2*WIDTH_P-1:0] m_gx_o,
    output logic signed [2*WIDTH_P-1:0] m_gy_o,
    output logic                        m_last_o,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int COL_W   = $clog2(IMG_W_P);
    localparam int ROW_W   = $clog2(IMG_H_P);
    localparam int FL_W    = $clog2(2 * IMG_W_P + 1);
    localparam int L_FLUSH = flush_beats(IMG_W_P);

    sobel_state_e     r_state;
    sobel_state_e     w_state_nxt;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [FL_W-1:0]  r_flush_cnt;
    logic             r_inflight;
    logic             r_infl_last;
    logic             r_done;

    logic             w_credit_ok;
    logic             w_conv_fire;
    logic             w_flush_fire;
    logic             w_pix_fire;
    logic             w_col_end;
    logic             w_row_end;
    logic             w_flush_end;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [1:0]       w_cnt;
    grad_t            w_push_dat;
    grad_t            w_head;

    // Same-cycle pops are deliberately not credited back.
    assign w_credit_ok  = (({1'b0, w_cnt}) + {2'b00, r_inflight}) < 3'd2;
    assign w_conv_fire  = conv_valid_o & conv_ready_i;
    assign w_flush_fire = (r_state == FLUSH) & w_conv_fire;
    assign w_pix_fire   = (r_state == RUN) & w_conv_fire;
    assign w_col_end    = (r_col == COL_W'(IMG_W_P - 1));
    assign w_row_end    = (r_row == ROW_W'(IMG_H_P - 1));
    assign w_flush_end  = w_flush_fire & (r_flush_cnt == FL_W'(L_FLUSH - 1));
    assign w_pop        = m_valid_o & m_ready_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start_i) w_state_nxt = FLUSH;
            FLUSH:   if (w_flush_end) w_state_nxt = RUN;
            RUN:     if (w_pix_fire & w_col_end & w_row_end) w_state_nxt = DRAIN;
            // The last-tagged entry leaving means the FIFO empties with nothing behind it.
            DRAIN:   if (w_pop & w_head.last & ~r_inflight) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        conv_valid_o = 1'b0;
        conv_data_o  = '0;
        s_ready_o    = 1'b0;
        busy_o       = (r_state != IDLE);
        unique case (r_state)
            FLUSH: begin
                conv_valid_o = 1'b1;
            end
            RUN: begin
                conv_valid_o = s_valid_i & w_credit_ok;
                s_ready_o    = conv_ready_i & w_credit_ok;
                conv_data_o  = s_data_i;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_col       <= '0;
            r_row       <= '0;
            r_flush_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_col       <= '0;
            r_row       <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_flush_fire) begin
                r_flush_cnt <= r_flush_cnt + FL_W'(1);
            end
            if (w_pix_fire) begin
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
        end
    end

    // conv2d output lags its input by one cycle; windows touching row/col 0..1 span a border.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_inflight  <= 1'b0;
            r_infl_last <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_inflight  <= w_pix_fire & (r_row >= ROW_W'(2)) & (r_col >= COL_W'(2));
            r_infl_last <= w_pix_fire & w_row_end & w_col_end;
            r_done      <= w_pop & w_head.last;
        end
    end

    assign w_push_dat = '{gx: conv_gx_i, gy: conv_gy_i, last: r_infl_last};

    sobel_grad_fifo u_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rstn_i),
        .i_push  (r_inflight),
        .i_dat   (w_push_dat),
        .i_pop   (w_pop),
        .o_dat   (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_cnt   (w_cnt)
    );

    assign m_valid_o = ~w_empty;
    assign m_gx_o    = w_head.gx;
    assign m_gy_o    = w_head.gy;
    assign m_last_o  = w_head.last;
    assign done_o    = r_done;

    no_overflow: assert property (@(posedge clk_i) disable iff (!rstn_i)
        !(r_inflight && w_full && !w_pop));

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl with a behavioural conv2d stand-in and an image-domain Sobel reference.
module tb_sobel_frame_ctrl;

    localparam int WD   = 8;
    localparam int IW   = 16;
    localparam int IH   = 16;
    localparam int NOUT = (IW - 2) * (IH - 2);
    localparam int NSH  = 2 * IW + 3;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [WD-1:0]     s_data = '0;
    logic              conv_valid;
    logic              conv_ready = 1'b1;
    logic [WD-1:0]     conv_data;
    logic signed [15:0] conv_gx = '0;
    logic signed [15:0] conv_gy = '0;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic signed [15:0] m_gx;
    logic signed [15:0] m_gy;
    logic              m_last;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    sobel_frame_ctrl #(.WIDTH_P(WD), .IMG_W_P(IW), .IMG_H_P(IH)) dut (
        .clk_i(clk), .rstn_i(rstn), .start_i(start),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
        .conv_valid_o(conv_valid), .conv_ready_i(conv_ready), .conv_data_o(conv_data),
        .conv_gx_i(conv_gx), .conv_gy_i(conv_gy),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_gx_o(m_gx), .m_gy_o(m_gy),
        .m_last_o(m_last), .busy_o(busy), .done_o(done)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input bit ok, input int act, input int exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int pix(input int pat, input int r, input int c);
        case (pat)
            0:       return r * 16 + c;
            1:       return 128;
            2:       return (c < 8) ? 0 : 255;
            3:       return 255;
            default: return (r * 37 + c * 11 + r * c) & 255;
        endcase
    endfunction

    // Reference Sobel taken straight from the image around centre (cr,cc).
    function automatic int ref_gx(input int pat, input int cr, input int cc);
        return (pix(pat, cr-1, cc+1) + 2*pix(pat, cr, cc+1) + pix(pat, cr+1, cc+1))
             - (pix(pat, cr-1, cc-1) + 2*pix(pat, cr, cc-1) + pix(pat, cr+1, cc-1));
    endfunction

    function automatic int ref_gy(input int pat, input int cr, input int cc);
        return (pix(pat, cr+1, cc-1) + 2*pix(pat, cr+1, cc) + pix(pat, cr+1, cc+1))
             - (pix(pat, cr-1, cc-1) + 2*pix(pat, cr-1, cc) + pix(pat, cr-1, cc+1));
    endfunction

    // conv2d stand-in: two line delays plus the current row, output registered one beat later.
    // Never reset, so stale history survives a mid-frame reset as in the real line RAM.
    int sh [NSH];
    initial for (int i = 0; i < NSH; i++) sh[i] = 0;

    always @(posedge clk) begin
        if (conv_valid && conv_ready) begin
            int p [3][3];
            for (int i = NSH - 1; i > 0; i--) sh[i] = sh[i-1];
            sh[0] = int'(conv_data);
            for (int dr = 0; dr < 3; dr++)
                for (int dc = 0; dc < 3; dc++)
                    p[dr][dc] = sh[(2 - dr) * IW + (2 - dc)];
            conv_gx <= 16'((p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]));
            conv_gy <= 16'((p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]));
        end
    end

    bit  mon_en = 1'b0;
    int  cur_pat = 0;
    int  out_idx = 0;
    int  sum_gx = 0;
    int  sum_gy = 0;
    int  done_cnt = 0;
    int  conv_beats = 0;
    bit  stall_prev = 1'b0;
    logic signed [15:0] hold_gx, hold_gy;
    logic hold_last;

    always @(negedge clk) begin
        if (mon_en) begin
            if (conv_valid && conv_ready) begin
                conv_beats++;
                if (conv_beats <= 2 * IW)
                    check("flush_beat", !s_ready && conv_data == '0, int'({s_ready, conv_data}), 0);
            end
            if (!busy)
                check("idle_quiet", !s_ready && !conv_valid && !m_valid,
                      int'({s_ready, conv_valid, m_valid}), 0);
            if (stall_prev)
                check("stall_hold", m_valid && m_gx == hold_gx && m_gy == hold_gy && m_last == hold_last,
                      int'(m_gx), int'(hold_gx));
            stall_prev = m_valid && !m_ready;
            hold_gx    = m_gx;
            hold_gy    = m_gy;
            hold_last  = m_last;
            if (m_valid && m_ready) begin
                if (out_idx >= NOUT) begin
                    check("extra_output", 1'b0, out_idx + 1, NOUT);
                end else begin
                    int cr, cc;
                    cr = out_idx / (IW - 2) + 1;
                    cc = out_idx % (IW - 2) + 1;
                    check("gx", int'(m_gx) == ref_gx(cur_pat, cr, cc), int'(m_gx), ref_gx(cur_pat, cr, cc));
                    check("gy", int'(m_gy) == ref_gy(cur_pat, cr, cc), int'(m_gy), ref_gy(cur_pat, cr, cc));
                    check("last", m_last == (out_idx == NOUT - 1), int'(m_last), int'(out_idx == NOUT - 1));
                end
                sum_gx += int'(m_gx);
                sum_gy += int'(m_gy);
                out_idx++;
            end
            if (done) begin
                done_cnt++;
                check("done_after_last", !busy && out_idx == NOUT, out_idx, NOUT);
            end
        end
    end

    typedef struct {
        int pat;
        int mr;
        int sv;
        int cr;
        bit start_mid;
        bit chk_sum;
        int exp_sgx;
        int exp_sgy;
    } vec_t;

    task automatic run_frame(input vec_t v, input int abort_at);
        int  pidx = 0;
        int  cyc = 0;
        bit  acc;
        bit  sm_done = 1'b0;
        cur_pat = v.pat; out_idx = 0; sum_gx = 0; sum_gy = 0;
        done_cnt = 0; conv_beats = 0; stall_prev = 1'b0; mon_en = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (done_cnt == 0 && cyc < 6000) begin
            s_valid    = (pidx < IW * IH) && ($urandom_range(99) < v.sv);
            s_data     = WD'(pix(v.pat, pidx / IW, pidx % IW));
            m_ready    = ($urandom_range(99) < v.mr);
            conv_ready = ($urandom_range(99) < v.cr);
            start      = v.start_mid && pidx == 50 && !sm_done;
            if (start) sm_done = 1'b1;
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) pidx++;
            cyc++;
            if (abort_at >= 0 && pidx == abort_at) return;
        end
        start = 1'b0; s_valid = 1'b0; m_ready = 1'b1; conv_ready = 1'b1;
        if (cyc >= 6000) check("frame_timeout", 1'b0, cyc, 6000);
        repeat (6) @(posedge clk);
        #1;
        check("out_count", out_idx == NOUT, out_idx, NOUT);
        check("done_pulses", done_cnt == 1, done_cnt, 1);
        check("conv_beats", conv_beats == 2 * IW + IW * IH, conv_beats, 2 * IW + IW * IH);
        check("busy_end", busy == 1'b0, int'(busy), 0);
        if (v.chk_sum) begin
            check("sum_gx", sum_gx == v.exp_sgx, sum_gx, v.exp_sgx);
            check("sum_gy", sum_gy == v.exp_sgy, sum_gy, v.exp_sgy);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"}, m_valid == 1'b0, int'(m_valid), 0);
        check({tag, "_s_ready"}, s_ready == 1'b0, int'(s_ready), 0);
        check({tag, "_conv_valid"}, conv_valid == 1'b0, int'(conv_valid), 0);
        check({tag, "_conv_data"}, conv_data == '0, int'(conv_data), 0);
        check({tag, "_busy"}, busy == 1'b0, int'(busy), 0);
        check({tag, "_done"}, done == 1'b0, int'(done), 0);
        check({tag, "_m_data"}, m_gx == '0 && m_gy == '0 && m_last == 1'b0, int'(m_gx), 0);
    endtask

    vec_t tbl [8];

    initial begin
        // Ramp 16r+c: gx=8, gy=128 everywhere; step edge gives 1020 at 28 window centres.
        tbl[0] = '{pat:0, mr:100, sv:100, cr:100, start_mid:0, chk_sum:1, exp_sgx:1568,  exp_sgy:25088};
        tbl[1] = '{pat:1, mr:100, sv:100, cr:100, start_mid:0, chk_sum:1, exp_sgx:0,     exp_sgy:0};
        tbl[2] = '{pat:2, mr:100, sv:100, cr:100, start_mid:0, chk_sum:1, exp_sgx:28560, exp_sgy:0};
        tbl[3] = '{pat:3, mr:100, sv:100, cr:100, start_mid:0, chk_sum:1, exp_sgx:0,     exp_sgy:0};
        tbl[4] = '{pat:0, mr:100, sv:100, cr:100, start_mid:0, chk_sum:1, exp_sgx:1568,  exp_sgy:25088};
        tbl[5] = '{pat:0, mr:30,  sv:50,  cr:100, start_mid:0, chk_sum:1, exp_sgx:1568,  exp_sgy:25088};
        tbl[6] = '{pat:4, mr:30,  sv:50,  cr:70,  start_mid:1, chk_sum:0, exp_sgx:0,     exp_sgy:0};
        tbl[7] = '{pat:0, mr:100, sv:100, cr:100, start_mid:1, chk_sum:1, exp_sgx:1568,  exp_sgy:25088};

        rstn = 1'b0;
        #3;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        s_valid = 1'b1;
        @(negedge clk);
        check("idle_s_ready", s_ready == 1'b0, int'(s_ready), 0);
        s_valid = 1'b0;

        for (int i = 0; i < 8; i++) run_frame(tbl[i], -1);

        run_frame(tbl[0], 100);
        mon_en = 1'b0;
        rstn   = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        s_valid = 1'b0; m_ready = 1'b1; conv_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        run_frame(tbl[0], -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
